dma_channel_seq: RTL

//  Single-channel DMA sequencer. Holds the channel registers AC (address counter),
//  WC (word counter), WR (word register) and CR (2-bit mode), requests the shared
//  bus, steps one word per bus handshake and stops on the CR-selected terminal

---
 rtl/dma_channel_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dma_channel_seq.sv
// Single-channel DMA sequencer.
//
// Holds the channel registers AC (address counter), WC (word counter), WR (word register)
// and CR (2-bit mode). It requests the shared bus, moves one word per grant/ack handshake
// and stops on the terminal condition that CR selects.
//
// Optional feature: define DMA_AUTOINIT_EN to enable auto-initialise. A shadow copy of AC
// is captured on every AC load. On the terminal word the channel reloads AC from the
// shadow copy, clears WC and re-arms itself instead of going idle. In this mode only
// abort or rst returns the channel to idle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   din                   CPU load data
//   ld_ac, ld_wr, ld_cr   register loads, honoured only while idle
//   start                 begin a transfer, honoured only while idle
//   abort                 cancel the transfer in progress
//   bus_req, bus_gnt      bus arbitration handshake
//   bus_addr              transfer address (AC) while a word is on the bus, else 0
//   bus_ack               slave completed the current word
//   busy                  channel not idle
//   done                  one-cycle pulse after the terminal word
//   tc                    sticky terminal-count flag, cleared by start
module dma_channel_seq #(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] din,
  input  logic             ld_ac,
  input  logic             ld_wr,
  input  logic             ld_cr,
  input  logic             start,
  input  logic             abort,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [NBITS-1:0] bus_addr,
  input  logic             bus_ack,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

  localparam logic [NBITS-1:0] One = {{(NBITS-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [NBITS-1:0] ac_q, ac_d;
  logic [NBITS-1:0] wc_q, wc_d;
  logic [NBITS-1:0] wr_q, wr_d;
  logic [1:0]       cr_q, cr_d;
  logic             tc_q, tc_d;
  logic [NBITS-1:0] ac_inc, wc_inc;
  logic             terminal;
`ifdef DMA_AUTOINIT_EN
  logic [NBITS-1:0] ac_init_q, ac_init_d;
`endif

  assign ac_inc = ac_q + One;
  assign wc_inc = wc_q + One;

  // Terminal condition, evaluated on the pre-increment counter values.
  always_comb begin
    terminal = 1'b0;
    case (cr_q)
      2'b00:   terminal = &wc_q;            // carry out of the WC increment
      2'b01:   terminal = (wc_inc == wr_q); // WR = 0 gives 2^NBITS words
      2'b10:   terminal = (ac_q == wr_q);   // last word lands at address WR
      default: terminal = 1'b0;             // free-running until abort
    endcase
  end

  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    wc_d    = wc_q;
    wr_d    = wr_q;
    cr_d    = cr_q;
    tc_d    = tc_q;
`ifdef DMA_AUTOINIT_EN
    ac_init_d = ac_init_q;
`endif
    case (state_q)
      StIdle: begin
        // Loads coincident with start land first, so the transfer uses the new values.
        if (ld_ac) begin
          ac_d = din;
`ifdef DMA_AUTOINIT_EN
          ac_init_d = din;
`endif
        end
        if (ld_wr) wr_d = din;
        if (ld_cr) cr_d = din[1:0];
        if (start) begin
          wc_d    = '0;
          tc_d    = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (abort)        state_d = StIdle;
        else if (bus_gnt) state_d = StXfer;
      end
      StXfer: begin
        // An acked word always counts, even when abort arrives in the same cycle.
        if (bus_ack) begin
          ac_d = ac_inc;
          wc_d = wc_inc;
        end
        if (abort)        state_d = StIdle;
        else if (bus_ack) state_d = terminal ? StDone : StReq;
      end
      StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          tc_d = 1'b1;
`ifdef DMA_AUTOINIT_EN
          ac_d    = ac_init_q;
          wc_d    = '0;
          state_d = StReq;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ac_q    <= '0;
      wc_q    <= '0;
      wr_q    <= '0;
      cr_q    <= 2'b00;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      wc_q    <= wc_d;
      wr_q    <= wr_d;
      cr_q    <= cr_d;
      tc_q    <= tc_d;
    end
  end

`ifdef DMA_AUTOINIT_EN
  always_ff @(posedge clk) begin
    if (rst) ac_init_q <= '0;
    else     ac_init_q <= ac_init_d;
  end
`endif

  assign bus_req  = (state_q == StReq) || (state_q == StXfer);
  assign bus_addr = (state_q == StXfer) ? ac_q : '0;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign tc       = tc_q;

endmodule
